// File: rtl/vend_pkg.sv
// Shared definitions for the vending actuator controller: channel indices,
// FSM state encoding and the fixed-priority channel picker.
package vend_pkg;

  localparam int NUM_CH = 4;

  // Channel indices; ascending index is also descending launch priority.
  localparam int CH_JOLT   = 0;
  localparam int CH_BUZZ   = 1;
  localparam int CH_DIME   = 2;
  localparam int CH_NICKEL = 3;

  // Per-channel pending counters saturate here.
  localparam logic [1:0] PEND_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Lowest set index wins: jolt > buzz > dime > nickel.
  function automatic logic [1:0] pick_channel(input logic [NUM_CH-1:0] req);
    logic [1:0] ch;
    ch = 2'(CH_NICKEL);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) ch = 2'(i);
    end
    return ch;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter shared by the FIRE and GAP phases. It stops at zero
// and flags it; a load always wins over counting.
module vend_pulse_timer #(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Count down toward zero, reloading on request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vend_actuator_ctrl.sv
// Vending actuator controller: accepts 1-cycle dispense/return strobes,
// queues them per channel, tracks product stock, and drives one solenoid at a
// time for a fixed on-time followed by a mandatory all-off gap.
module vend_actuator_ctrl
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 5000000,
  parameter int GAP_CYCLES   = 2500000,
  parameter int STOCK_INIT   = 8,
  parameter int CNT_W        = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dispense_jolt,
  input  logic       dispense_buzz,
  input  logic       return_nickel,
  input  logic       return_dime,
  input  logic       restock,
  output logic       sol_jolt,
  output logic       sol_buzz,
  output logic       sol_nickel,
  output logic       sol_dime,
  output logic       busy,
  output logic [3:0] jolt_stock,
  output logic [3:0] buzz_stock,
  output logic       jolt_empty,
  output logic       buzz_empty,
  output logic       req_dropped
);

  localparam logic [3:0]       STOCK_FULL = 4'(STOCK_INIT);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [NUM_CH-1:0] sol;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] pend_nz;
  logic [NUM_CH-1:0] launch_vec;
  logic [1:0]        pend [NUM_CH];
  logic [3:0]        stock [2];
  logic              launch;
  logic [1:0]        pick;
  logic              t_load;
  logic [CNT_W-1:0]  t_load_val;
  logic              t_zero;

  assign strobe[CH_JOLT]   = dispense_jolt;
  assign strobe[CH_BUZZ]   = dispense_buzz;
  assign strobe[CH_DIME]   = return_dime;
  assign strobe[CH_NICKEL] = return_nickel;

  // Acceptance, arbitration and launch decode from the current registered state.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so
    // no path can leave it unassigned and imply a latch.
    accept     = '0;
    pend_nz    = '0;
    launch_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_nz[i] = (pend[i] != 2'd0);
      accept[i]  = strobe[i] && (pend[i] != PEND_MAX);
    end
    // Product channels also need a unit on the shelf; a same-cycle restock
    // supplies one.
    accept[CH_JOLT] = accept[CH_JOLT] && ((stock[CH_JOLT] != 4'd0) || restock);
    accept[CH_BUZZ] = accept[CH_BUZZ] && ((stock[CH_BUZZ] != 4'd0) || restock);

    pick   = pick_channel(pend_nz);
    launch = (state == ST_IDLE) && (pend_nz != '0);
    for (int i = 0; i < NUM_CH; i++) begin
      launch_vec[i] = launch && (pick == 2'(i));
    end

    t_load     = launch || ((state == ST_FIRE) && t_zero);
    t_load_val = launch ? PULSE_LOAD : GAP_LOAD;
  end

  // Pending counters: +1 on accept, -1 on launch, both together cancel.
  always_ff @(posedge clk) begin
    // NOTE: these small counter arrays are plain flops, so they are cleared
    // explicitly on reset like any other state register.
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) pend[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: non-blocking updates, so every channel and every other block
        // sees the same pre-edge pend values in this cycle.
        case ({accept[i], launch_vec[i]})
          2'b10:   pend[i] <= pend[i] + 2'd1;
          2'b01:   pend[i] <= pend[i] - 2'd1;
          default: pend[i] <= pend[i];
        endcase
      end
    end
  end

  // Stock: consumed at acceptance; restock refills, minus any same-cycle sale.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) stock[i] <= STOCK_FULL;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (restock) begin
          stock[i] <= accept[i] ? STOCK_FULL - 4'd1 : STOCK_FULL;
        end else if (accept[i]) begin
          stock[i] <= stock[i] - 4'd1;
        end
      end
    end
  end

  // Sticky flag for any strobe that could not be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_dropped <= 1'b0;
    end else if ((strobe & ~accept) != '0) begin
      req_dropped <= 1'b1;
    end
  end

  // Pulse sequencer: IDLE picks a channel, FIRE holds its solenoid, GAP rests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sol   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sol <= '0;
          if (launch) begin
            sol   <= launch_vec;
            state <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          if (t_zero) begin
            sol   <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          sol <= '0;
          if (t_zero) state <= ST_IDLE;
        end
        default: begin
          sol   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  vend_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  assign sol_jolt    = sol[CH_JOLT];
  assign sol_buzz    = sol[CH_BUZZ];
  assign sol_dime    = sol[CH_DIME];
  assign sol_nickel  = sol[CH_NICKEL];
  assign busy        = (state != ST_IDLE) || (pend_nz != '0);
  assign jolt_stock  = stock[CH_JOLT];
  assign buzz_stock  = stock[CH_BUZZ];
  assign jolt_empty  = (stock[CH_JOLT] == 4'd0);
  assign buzz_empty  = (stock[CH_BUZZ] == 4'd0);

endmodule

// File: tb/tb_vend_actuator_ctrl.sv
// Self-checking bench for vend_actuator_ctrl with short pulse/gap timing.
// A cycle table covers the basic pulse and the dime/nickel ordering; hand
// sequences cover stock exhaustion, queue saturation, restock and reset.
// A monitor pops an expected-pulse scoreboard on every solenoid rising edge.
module tb_vend_actuator_ctrl;
  import vend_pkg::*;

  localparam int P = 4;
  localparam int G = 2;
  localparam int S = 2;

  logic       clk;
  logic       reset;
  logic       restock;
  logic [3:0] strb;
  logic       sol_jolt, sol_buzz, sol_nickel, sol_dime;
  logic       busy, jolt_empty, buzz_empty, req_dropped;
  logic [3:0] jolt_stock, buzz_stock;
  logic [3:0] sol_vec;

  assign sol_vec = {sol_nickel, sol_dime, sol_buzz, sol_jolt};

  vend_actuator_ctrl #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .STOCK_INIT   (S),
    .CNT_W        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dispense_jolt (strb[CH_JOLT]),
    .dispense_buzz (strb[CH_BUZZ]),
    .return_nickel (strb[CH_NICKEL]),
    .return_dime   (strb[CH_DIME]),
    .restock       (restock),
    .sol_jolt      (sol_jolt),
    .sol_buzz      (sol_buzz),
    .sol_nickel    (sol_nickel),
    .sol_dime      (sol_dime),
    .busy          (busy),
    .jolt_stock    (jolt_stock),
    .buzz_stock    (buzz_stock),
    .jolt_empty    (jolt_empty),
    .buzz_empty    (buzz_empty),
    .req_dropped   (req_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: ordering against the scoreboard, pulse width, exclusivity.
  logic [3:0] prev_sol;
  int         width [4];
  always @(negedge clk) begin
    if (reset) begin
      prev_sol = '0;
      for (int i = 0; i < 4; i++) width[i] = 0;
    end else begin
      check("sol_onehot", ($countones(sol_vec) > 1) ? 32'd1 : 32'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (sol_vec[i] && !prev_sol[i]) begin
          if (sb_q.size() == 0) check("sb_unexpected_pulse", 32'(i), 32'hff);
          else                  check("sb_channel", 32'(i), 32'(sb_q.pop_front()));
          width[i] = 1;
        end else if (sol_vec[i]) begin
          width[i]++;
        end else if (prev_sol[i]) begin
          check("pulse_width", 32'(width[i]), 32'(P));
        end
      end
      prev_sol = sol_vec;
    end
  end

  // Hard stop in case a wait ever misbehaves.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] strb;
    logic       rs;
    int         n;
    logic [3:0] sol;
    logic       busy;
    logic [3:0] js;
    logic [3:0] bs;
    logic       drop;
    logic [3:0] push;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic [3:0] s, int n, logic [3:0] sol, logic b,
                              logic [3:0] js, logic [3:0] push);
    vec_t v;
    v.strb = s;  v.rs = 1'b0; v.n = n;  v.sol = sol; v.busy = b;
    v.js   = js; v.bs = 4'(S); v.drop = 1'b0; v.push = push;
    return v;
  endfunction

  task automatic push_mask(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) sb_q.push_back(i);
  endtask

  // Present inputs for the current cycle; they are sampled at the next edge.
  task automatic drive(input logic [3:0] s, input logic r);
    strb    = s;
    restock = r;
    @(posedge clk);
    #1;
    strb    = '0;
    restock = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    strb    = '0;
    restock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    strb    = '0;
    restock = 1'b0;

    // Single jolt pulse, then dime+nickel together (dime wins, nickel after gap).
    tbl[0]  = mk(4'b0001, 1, 4'b0000, 1'b0, 4'd2, 4'b0001);
    tbl[1]  = mk(4'b0000, 1, 4'b0000, 1'b1, 4'd1, 4'b0000);
    tbl[2]  = mk(4'b0000, P, 4'b0001, 1'b1, 4'd1, 4'b0000);
    tbl[3]  = mk(4'b0000, G, 4'b0000, 1'b1, 4'd1, 4'b0000);
    tbl[4]  = mk(4'b0000, 2, 4'b0000, 1'b0, 4'd1, 4'b0000);
    tbl[5]  = mk(4'b1100, 1, 4'b0000, 1'b0, 4'd1, 4'b1100);
    tbl[6]  = mk(4'b0000, 1, 4'b0000, 1'b1, 4'd1, 4'b0000);
    tbl[7]  = mk(4'b0000, P, 4'b0100, 1'b1, 4'd1, 4'b0000);
    tbl[8]  = mk(4'b0000, G + 1, 4'b0000, 1'b1, 4'd1, 4'b0000);
    tbl[9]  = mk(4'b0000, P, 4'b1000, 1'b1, 4'd1, 4'b0000);
    tbl[10] = mk(4'b0000, G, 4'b0000, 1'b1, 4'd1, 4'b0000);
    tbl[11] = mk(4'b0000, 1, 4'b0000, 1'b0, 4'd1, 4'b0000);

    do_reset();
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        strb    = (k == 0) ? tbl[r].strb : 4'b0000;
        restock = (k == 0) ? tbl[r].rs : 1'b0;
        if (k == 0) push_mask(tbl[r].push);
        @(negedge clk);
        check($sformatf("vec%0d.%0d", r, k),
              32'({sol_vec, busy, jolt_stock, buzz_stock, jolt_empty, buzz_empty, req_dropped}),
              32'({tbl[r].sol, tbl[r].busy, tbl[r].js, tbl[r].bs,
                   tbl[r].js == 4'd0, tbl[r].bs == 4'd0, tbl[r].drop}));
        @(posedge clk);
        #1;
        strb    = '0;
        restock = 1'b0;
      end
    end
    check("sb_drained_basic", 32'(sb_q.size()), 32'd0);

    // Three consecutive jolt strobes with two units: third is dropped.
    do_reset();
    push_mask(4'b0001);
    push_mask(4'b0001);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    @(negedge clk);
    check("exhaust_stock_after2", 32'(jolt_stock), 32'd0);
    check("exhaust_no_drop_yet", 32'(req_dropped), 32'd0);
    drive(4'b0001, 1'b0);
    @(negedge clk);
    check("exhaust_empty", 32'(jolt_empty), 32'd1);
    check("exhaust_dropped", 32'(req_dropped), 32'd1);
    wait_idle(60, "exhaust_idle");
    check("exhaust_sb_drained", 32'(sb_q.size()), 32'd0);
    check("exhaust_stock_final", 32'(jolt_stock), 32'd0);

    // Four nickel strobes during a buzz pulse: pending saturates at three.
    do_reset();
    push_mask(4'b0010);
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    push_mask(4'b1000);
    push_mask(4'b1000);
    push_mask(4'b1000);
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    @(negedge clk);
    check("sat_buzz_still_firing", 32'(sol_vec), 32'b0010);
    check("sat_no_drop_yet", 32'(req_dropped), 32'd0);
    drive(4'b1000, 1'b0);
    @(negedge clk);
    check("sat_dropped", 32'(req_dropped), 32'd1);
    wait_idle(80, "sat_idle");
    check("sat_sb_drained", 32'(sb_q.size()), 32'd0);
    check("sat_buzz_stock", 32'(buzz_stock), 32'd1);

    // Restock together with a buzz dispense while buzz is empty.
    do_reset();
    push_mask(4'b0010);
    push_mask(4'b0010);
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0010, 1'b0);
    @(negedge clk);
    check("restock_pre_stock", 32'(buzz_stock), 32'd0);
    check("restock_pre_empty", 32'(buzz_empty), 32'd1);
    wait_idle(60, "restock_pre_idle");
    push_mask(4'b0010);
    drive(4'b0010, 1'b1);
    @(negedge clk);
    check("restock_buzz_stock", 32'(buzz_stock), 32'(S - 1));
    check("restock_jolt_stock", 32'(jolt_stock), 32'(S));
    check("restock_no_drop", 32'(req_dropped), 32'd0);
    wait_idle(60, "restock_idle");
    check("restock_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset in the second cycle of a jolt pulse, with another jolt pending.
    do_reset();
    push_mask(4'b0001);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pulse_on", 32'(sol_jolt), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_sol_low", 32'(sol_vec), 32'd0);
    check("rst_stocks", 32'({jolt_stock, buzz_stock}), 32'({4'(S), 4'(S)}));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(req_dropped), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_no_more_pulses", 32'({sol_vec, busy}), 32'd0);
    end
    check("rst_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
